// File: rtl/mem_array_ctrl.sv
// mem_array_ctrl: parametrised single-clock word store.
//   The decoder side writes through a byte-lane-masked port.
//   The test side reads through a port with registered data and a valid strobe.
//   A clear engine zeroes one word per cycle after reset and whenever clear is
//   requested. busy is high while that sweep runs.
//   An access to an address >= DEPTH is dropped and flagged on err for one cycle.
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   clear / busy      clear-sweep request (sampled in READY) / sweep in progress
//   wr_en/addr/data/be  write port with byte-lane enables
//   rd_en/addr        read request
//   rd_data/rd_valid  registered read data and strobe
//   err               one-cycle pulse for a dropped out-of-range access
module mem_array_ctrl #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic [WORD_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [WORD_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                err
);

  localparam int BE_W  = WORD_W / 8;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2^ADDR_W is still representable.
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;

  logic [WORD_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [CNT_W-1:0]    mem_waddr;
  logic [WORD_W-1:0]   mem_wdata;
  logic [BE_W-1:0]     mem_wbe;

  logic                wr_in, rd_in;
  logic [CNT_W-1:0]    wr_idx, rd_idx;

  assign wr_in  = ({1'b0, wr_addr} < DEPTH_A);
  assign rd_in  = ({1'b0, rd_addr} < DEPTH_A);
  assign wr_idx = wr_addr[CNT_W-1:0];
  assign rd_idx = rd_addr[CNT_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_idx;
    mem_wdata  = wr_data;
    mem_wbe    = wr_be;

    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        if (clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
        mem_we = wr_en && wr_in;
        if (rd_en) begin
          rd_valid_d = 1'b1;
          // The array is read before this edge's write lands, so a
          // same-address collision returns the old word.
          rd_data_d  = rd_in ? mem[rd_idx] : '0;
        end
        err_d = (wr_en && !wr_in) || (rd_en && !rd_in);
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Array contents are left untouched while reset is held.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int unsigned k = 0; k < BE_W; k++) begin
        if (mem_wbe[k]) mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
    end
  end

  assign busy     = (state_q == CLEAR);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule
